// File: rtl/cache_controller.sv
// Two-way set-associative, write-back, write-allocate texture cache: 16 sets x 64-bit lines, two-beat 32-bit memory port.
// Define CACHE_LRU_EN for per-set LRU replacement; otherwise a global fill toggle picks the victim.
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] u,
    input  logic [11:0] v,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] data_in,
    output logic        accept,
    output logic [15:0] pixel_out,
    output logic        pixel_ready,
    output logic [19:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    input  logic [31:0] mem_rddata,
    output logic [63:0] mem_wrdata
);

    localparam int unsigned SETS   = 16;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned SET_W  = 4;
    localparam int unsigned TAG_W  = 18;
    localparam int unsigned LINE_W = 64;
    localparam int unsigned PIX_W  = 16;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP, HOLD
    } state_t;

    state_t      state_q;
    logic        op_write_q;
    logic [11:0] u_q;
    logic [11:0] v_q;
    logic [63:0] din_q;
    logic        victim_q;
    logic        beat_q;

    logic [LINE_W-1:0] data_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
`ifdef CACHE_LRU_EN
    logic [SETS-1:0] lru_q;
`else
    logic toggle_q;
`endif

    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [19:0]       req_addr;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              repl_c;
    logic              victim_c;
    logic              access_way;
    logic              vic_dirty;
    logic              lookup_hit;
    logic [19:0]       vic_addr;
    logic [LINE_W-1:0] line_c;
    logic [PIX_W-1:0]  pix_c;
    logic              we_hi;
    logic              we_lo;
    logic              wway;
    logic [31:0]       whi;
    logic [31:0]       wlo;

    // Lookup, victim choice and array write controls for the held request
    always_comb begin
        set_idx  = {v_q[1:0], u_q[5:4]};
        req_tag  = {v_q[11:2], u_q[11:6], u_q[3:2]};
        req_addr = {1'b0, v_q[9:0], u_q[9:2], 1'b0};

        hit0    = valid_q[set_idx][0] && (tag_q[set_idx][0] == req_tag);
        hit1    = valid_q[set_idx][1] && (tag_q[set_idx][1] == req_tag);
        hit     = hit0 || hit1;
        hit_way = !hit0;

`ifdef CACHE_LRU_EN
        repl_c = lru_q[set_idx];
`else
        repl_c = toggle_q;
`endif
        victim_c = repl_c;
        if (!valid_q[set_idx][1]) victim_c = 1'b1;
        if (!valid_q[set_idx][0]) victim_c = 1'b0;

        access_way = hit ? hit_way : victim_c;
        vic_dirty  = valid_q[set_idx][victim_c] && dirty_q[set_idx][victim_c];
        lookup_hit = (state_q == LOOKUP) && hit;

        // Evicted line address is rebuilt from its stored tag and this set
        vic_addr = {1'b0, tag_q[set_idx][victim_q][15:8], set_idx[3:2],
                    tag_q[set_idx][victim_q][5:2], set_idx[1:0],
                    tag_q[set_idx][victim_q][1:0], 1'b0};
        line_c   = data_q[set_idx][victim_q];

        pix_c = line_c[63:48];
        case (u_q[1:0])
            2'd0: pix_c = line_c[63:48];
            2'd1: pix_c = line_c[47:32];
            2'd2: pix_c = line_c[31:16];
            2'd3: pix_c = line_c[15:0];
            default: pix_c = line_c[63:48];
        endcase

        we_hi = 1'b0;
        we_lo = 1'b0;
        wway  = (state_q == LOOKUP) ? access_way : victim_q;
        whi   = din_q[63:32];
        wlo   = din_q[31:0];
        case (state_q)
            LOOKUP: begin
                if (op_write_q && (hit || !vic_dirty)) begin
                    we_hi = 1'b1;
                    we_lo = 1'b1;
                end
            end
            WB_WAIT: begin
                if (mem_ready && beat_q && op_write_q) begin
                    we_hi = 1'b1;
                    we_lo = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    whi   = mem_rddata;
                    wlo   = mem_rddata;
                    we_hi = !beat_q;
                    we_lo = beat_q;
                end
            end
            default: ;
        endcase
    end

    // Data and tag arrays carry no reset; valid bits gate them
    always_ff @(posedge clk) begin
        if (we_hi) data_q[set_idx][wway][63:32] <= whi;
        if (we_lo) begin
            data_q[set_idx][wway][31:0] <= wlo;
            tag_q[set_idx][wway]        <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_write_q  <= 1'b0;
            u_q         <= '0;
            v_q         <= '0;
            din_q       <= '0;
            victim_q    <= 1'b0;
            beat_q      <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
`ifdef CACHE_LRU_EN
            lru_q       <= '0;
`else
            toggle_q    <= 1'b0;
`endif
            accept      <= 1'b0;
            pixel_out   <= '0;
            pixel_ready <= 1'b0;
            mem_addr    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_wrdata  <= '0;
        end else begin
            // Any full-line install (write or fill completion) marks the way valid
            if (we_lo) begin
                valid_q[set_idx][wway] <= 1'b1;
                dirty_q[set_idx][wway] <= op_write_q;
            end
`ifdef CACHE_LRU_EN
            if (we_lo || lookup_hit) lru_q[set_idx] <= !wway;
`else
            if (we_lo && !lookup_hit) toggle_q <= !toggle_q;
`endif
            case (state_q)
                IDLE: begin
                    if (write || read) begin
                        op_write_q <= write;
                        u_q        <= u;
                        v_q        <= v;
                        din_q      <= data_in;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    victim_q <= access_way;
                    beat_q   <= 1'b0;
                    if (hit)              state_q <= RESP;
                    else if (vic_dirty)   state_q <= WB_REQ;
                    else if (!op_write_q) state_q <= RD_REQ;
                    else                  state_q <= RESP;
                end
                WB_REQ: begin
                    mem_write  <= 1'b1;
                    mem_addr   <= vic_addr;
                    mem_wrdata <= line_c;
                    state_q    <= WB_WAIT;
                end
                WB_WAIT: begin
                    mem_write <= 1'b0;
                    if (mem_ready) begin
                        beat_q <= !beat_q;
                        if (beat_q) begin
                            if (!op_write_q) dirty_q[set_idx][victim_q] <= 1'b0;
                            state_q <= op_write_q ? RESP : RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    mem_read <= 1'b1;
                    mem_addr <= req_addr;
                    beat_q   <= 1'b0;
                    state_q  <= RD_WAIT;
                end
                RD_WAIT: begin
                    mem_read <= 1'b0;
                    if (mem_ready) begin
                        beat_q <= !beat_q;
                        if (beat_q) state_q <= RESP;
                    end
                end
                RESP: begin
                    accept      <= 1'b1;
                    pixel_ready <= !op_write_q;
                    if (!op_write_q) pixel_out <= pix_c;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    accept      <= 1'b0;
                    pixel_ready <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a two-beat backing-memory model that stores writebacks.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic [11:0] u;
    logic [11:0] v;
    logic        read;
    logic        write;
    logic [63:0] data_in;
    logic        accept;
    logic [15:0] pixel_out;
    logic        pixel_ready;
    logic [19:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rddata = '0;
    logic [63:0] mem_wrdata;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [logic [19:0]];
    int          n_rd = 0;
    int          n_wr = 0;
    logic [19:0] last_rd_addr = '0;
    logic [19:0] last_wr_addr = '0;
    logic [63:0] last_wr_data = '0;
    int          mem_lat = 0;
    bit          busy = 0;
    bit          is_rd = 0;
    int          cnt = 0;
    int          beat = 0;
    logic [63:0] line = '0;

`ifdef CACHE_LRU_EN
    localparam logic [19:0] WB2_ADDR      = 20'h0BC94;
    localparam logic [63:0] WB2_DATA      = 64'hFEDCBA9876543210;
    localparam logic [15:0] PIX_AFTER_RST = 16'h0000;
`else
    localparam logic [19:0] WB2_ADDR      = 20'h0B492;
    localparam logic [63:0] WB2_DATA      = 64'hDECADE501DC0FFEE;
    localparam logic [15:0] PIX_AFTER_RST = 16'hFFEE;
`endif

    cache_controller dut (
        .clk        (clk),
        .rst        (rst),
        .u          (u),
        .v          (v),
        .read       (read),
        .write      (write),
        .data_in    (data_in),
        .accept     (accept),
        .pixel_out  (pixel_out),
        .pixel_ready(pixel_ready),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_ready  (mem_ready),
        .mem_rddata (mem_rddata),
        .mem_wrdata (mem_wrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory: latches each command on the falling edge, then returns two beats after mem_lat idle cycles
    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rst) begin
            busy = 0;
        end else begin
            if (mem_read || mem_write) check("mem_excl", 64'(mem_read & mem_write), 64'd0);
            if (mem_write) begin
                n_wr++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wrdata;
                mem[mem_addr] = mem_wrdata;
                busy = 1; is_rd = 0; cnt = mem_lat; beat = 0;
            end
            if (mem_read) begin
                n_rd++;
                last_rd_addr = mem_addr;
                line = mem.exists(mem_addr) ? mem[mem_addr] : 64'd0;
                busy = 1; is_rd = 1; cnt = mem_lat; beat = 0;
            end
            if (busy) begin
                if (cnt > 0) begin
                    cnt--;
                end else begin
                    check("addr_hold", 64'(mem_addr), 64'(is_rd ? last_rd_addr : last_wr_addr));
                    if (!is_rd) check("wrdata_hold", mem_wrdata, last_wr_data);
                    mem_ready  = 1'b1;
                    mem_rddata = (beat == 0) ? line[63:32] : line[31:0];
                    beat++;
                    if (beat == 2) busy = 0;
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [11:0] uu, input logic [11:0] vv,
                          input logic [63:0] d, output int lat, output logic [15:0] pix,
                          output bit rdy);
        bit done;
        done = 0;
        @(negedge clk);
        u = uu; v = vv; data_in = d; write = wr; read = !wr;
        lat = 0; pix = '0; rdy = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (accept) begin
                done = 1;
                pix  = pixel_out;
                rdy  = pixel_ready;
            end
        end
        write = 0; read = 0;
        check("req_accept", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic txn(input string tag, input bit wr, input logic [11:0] uu, input logic [11:0] vv,
                       input logic [63:0] d, input int exp_lat, input logic [15:0] exp_pix,
                       input int exp_wr, input int exp_rd);
        int lat;
        logic [15:0] pix;
        bit rdy;
        int wr0;
        int rd0;
        wr0 = n_wr;
        rd0 = n_rd;
        do_req(wr, uu, vv, d, lat, pix, rdy);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rdy"}, 64'(rdy), 64'(!wr));
        if (!wr) check({tag, "_pix"}, 64'(pix), 64'(exp_pix));
        check({tag, "_wb"}, 64'(n_wr - wr0), 64'(exp_wr));
        check({tag, "_fetch"}, 64'(n_rd - rd0), 64'(exp_rd));
    endtask

    initial begin
        bit seen;
        rst = 1'b1; u = '0; v = '0; read = 1'b0; write = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_accept", 64'(accept), 64'd0);
        check("rst_pixel_ready", 64'(pixel_ready), 64'd0);
        check("rst_pixel_out", 64'(pixel_out), 64'd0);
        check("rst_mem_read", 64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        txn("w123_miss", 1, 12'h123, 12'h456, 64'h0123456789ABCDEF, 3, 16'h0, 0, 0);
        txn("w127_miss", 1, 12'h127, 12'h45A, 64'h57A1E70A57EDBEEF, 3, 16'h0, 0, 0);
        txn("w127_hit",  1, 12'h127, 12'h45A, 64'hDECADE501DC0FFEE, 3, 16'h0, 0, 0);
        txn("w12b_evict", 1, 12'h12B, 12'h45E, 64'hFEDCBA9876543210, 6, 16'h0, 1, 0);
        check("w12b_wb_addr", 64'(last_wr_addr), 64'h0AC90);
        check("w12b_wb_data", last_wr_data, 64'h0123456789ABCDEF);

        txn("r12b_hit", 0, 12'h12B, 12'h45E, 64'h0, 3, 16'h3210, 0, 0);
        txn("r127_hit", 0, 12'h127, 12'h45A, 64'h0, 3, 16'hFFEE, 0, 0);
        txn("r123_miss", 0, 12'h123, 12'h456, 64'h0, 9, 16'hCDEF, 1, 1);
        check("r123_wb_addr", 64'(last_wr_addr), 64'(WB2_ADDR));
        check("r123_wb_data", last_wr_data, WB2_DATA);
        check("r123_fetch_addr", 64'(last_rd_addr), 64'h0AC90);
        txn("r120_hit", 0, 12'h120, 12'h456, 64'h0, 3, 16'h0123, 0, 0);
        txn("r121_hit", 0, 12'h121, 12'h456, 64'h0, 3, 16'h4567, 0, 0);

        // Abort a fill in progress with reset; memory is kept slow so the fill cannot finish first
        mem_lat = 20;
        seen = 0;
        @(negedge clk);
        u = 12'h040; v = 12'h000; read = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mem_read) seen = 1;
        end
        check("abort_fetch_issued", 64'(seen), 64'd1);
        check("abort_fetch_addr", 64'(mem_addr), 64'h00020);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_accept", 64'(accept), 64'd0);
        check("abort_pixel_ready", 64'(pixel_ready), 64'd0);
        check("abort_pixel_out", 64'(pixel_out), 64'd0);
        check("abort_mem_read", 64'(mem_read), 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        check("abort_mem_wrdata", mem_wrdata, 64'd0);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_lat = 0;

        txn("r127_after_rst", 0, 12'h127, 12'h45A, 64'h0, 6, PIX_AFTER_RST, 0, 1);
        check("r127_after_rst_addr", 64'(last_rd_addr), 64'h0B492);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
